tex_perf_counters: RTL and testbench
====================================

// Module: tex_perf_counters
// PURPOSE
//  Multi-channel performance-counter engine for the texture unit. Watches NUM_REQS texture memory
//  request/response channels plus the unit stall signal. Accumulates mem_reads, mem_latency and
//  stall_cycles, and drives them onto the tex perf master modport.
//  Adds over the fixed 3-counter bundle: per-channel fire counting, in-flight tracking, enable/clear
//  controls, a saturate-or-wrap mode and a sticky error flag.
// PARAMETERS
//  NUM_REQS     4    number of memory request/response channels (1..16)
//  CTR_W        44   counter width (= PERF_CTR_BITS)
//  MAX_PENDING  64   max in-flight reads tracked; PEND_W = $clog2(MAX_PENDING+1)
//  SATURATE     0    1: counters stick at all-ones; 0: counters wrap modulo 2^CTR_W
// PORTS
//  clk            in   1         clock
//  reset          in   1         synchronous, active-low reset
//  perf_en        in   1         1: counters accumulate; 0: counters hold
//  clear          in   1         zero the three counters (one-cycle pulse)
//  mem_req_valid  in   NUM_REQS  request valid, per channel
//  mem_req_ready  in   NUM_REQS  request ready, per channel
//  mem_rsp_valid  in   NUM_REQS  response valid, per channel
//  mem_rsp_ready  in   NUM_REQS  response ready, per channel
//  stall          in   1         texture pipeline stalled this cycle
//  mem_reads      out  CTR_W     total request handshakes
//  mem_latency    out  CTR_W     sum over cycles of in-flight read count
//  stall_cycles   out  CTR_W     cycles with stall=1
//  pending        out  PEND_W    current in-flight reads
//  err            out  1         sticky: pending overflow or underflow occurred
// BEHAVIOUR
//  Reset (reset=0 at posedge): all outputs 0, err=0; reset overrides clear and events in that cycle.
//  Fire definitions: req_fire[i]=valid&ready; rsp_fire[i]=valid&ready.
//  Counts: nreq=popcount(req_fire), nrsp=popcount(rsp_fire).
//  Outputs are registered; an event at cycle t appears on the outputs from t+1.
//  pending: always tracked, regardless of perf_en or clear.
//   next = pending_q + nreq - nrsp, computed at PEND_W+1 signed width.
//   next<0: clamp to 0 and set err. next>MAX_PENDING: clamp to MAX_PENDING and set err.
//   err is cleared only by reset (not by clear).
//  Counter update, perf_en=1:
//   mem_reads    += nreq.
//   mem_latency  += pending_q (pre-update value; reqs firing at t count from t+1).
//   stall_cycles += stall.
//   Operands zero-extended to CTR_W.
//  perf_en=0: all three counters hold; pending and err still update.
//  clear=1: all three counters load 0; same-cycle events are discarded (clear wins over increment).
//  Overflow: SATURATE=1, sum >= 2^CTR_W -> all-ones, then hold. SATURATE=0 -> modulo 2^CTR_W.
//  Simultaneous req and rsp on one channel: both counted. A rsp may fire in the same cycle as its req.
//  No handshake is generated; the block only observes, with no combinational path input->output.
// TESTING
//  1. Reset: hold reset=0 for 2 cycles with all valids/readies=1 -> every output 0, err=0.
//  2. perf_en=1; ch0 and ch2 fire a req at t0; no rsp.
//     -> mem_reads=2, pending=2 at t1; mem_latency grows 2/cycle from t2; 5 cycles later it is 10.
//  3. Responses on all 4 channels with pending=2 -> pending clamps to 0, err=1; err persists after clear.
//  4. perf_en=0 for 8 cycles with stall=1 and 3 reqs -> counters unchanged, pending=3.
//     Re-enable with stall=1 -> stall_cycles +1/cycle.
//  5. clear=1 in the same cycle as a req and stall -> counters 0 next cycle, pending still +1.
//  6. CTR_W=8: preload by 250 stall cycles, then 10 more.
//     SATURATE=1 -> stall_cycles=255. SATURATE=0 -> stall_cycles=4.

Source files
------------

// File: rtl/tex_perf_counters_if.sv
// Texture perf-counter bus: the observed memory request/response channels and
// stall signal, plus the accumulated counters driven back by the counter engine.
interface tex_perf_counters_if #(
  parameter int NUM_REQS = 4,
  parameter int CTR_W    = 44,
  parameter int PEND_W   = 7
);
  logic [NUM_REQS-1:0] mem_req_valid;
  logic [NUM_REQS-1:0] mem_req_ready;
  logic [NUM_REQS-1:0] mem_rsp_valid;
  logic [NUM_REQS-1:0] mem_rsp_ready;
  logic                stall;
  logic [CTR_W-1:0]    mem_reads;
  logic [CTR_W-1:0]    mem_latency;
  logic [CTR_W-1:0]    stall_cycles;
  logic [PEND_W-1:0]   pending;
  logic                err;

  // The counter engine observes the channels and drives the counters.
  modport master (
    input  mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready, stall,
    output mem_reads, mem_latency, stall_cycles, pending, err
  );

  // The surrounding texture unit drives the channels and reads the counters.
  modport slave (
    output mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready, stall,
    input  mem_reads, mem_latency, stall_cycles, pending, err
  );
endinterface

// File: rtl/tex_perf_counters.sv
// Multi-channel texture performance-counter engine. Counts request handshakes,
// accumulates in-flight read occupancy as a latency sum, counts stall cycles,
// and tracks the in-flight read count with a sticky over/underflow flag.
// All outputs are registered; the block only observes the handshakes.
module tex_perf_counters #(
  parameter int NUM_REQS    = 4,
  parameter int CTR_W       = 44,
  parameter int MAX_PENDING = 64,
  parameter int SATURATE    = 0,
  localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  perf_en,
  input  logic                  clear,
  tex_perf_counters_if.master   perf
);

  localparam int CNT_W  = $clog2(NUM_REQS + 1);
  // Signed working width large enough for pending + NUM_REQS and for -NUM_REQS.
  localparam int CALC_W = ((PEND_W > CNT_W) ? PEND_W : CNT_W) + 2;

  logic [NUM_REQS-1:0] req_fire;
  logic [NUM_REQS-1:0] rsp_fire;
  logic [CNT_W-1:0]    nreq;
  logic [CNT_W-1:0]    nrsp;

  logic [PEND_W-1:0]        pending_q;
  logic [PEND_W-1:0]        pending_d;
  logic                     pend_err;
  logic signed [CALC_W-1:0] pend_sum;

  logic [CTR_W-1:0] mem_reads_q;
  logic [CTR_W-1:0] mem_latency_q;
  logic [CTR_W-1:0] stall_cycles_q;
  logic [CTR_W-1:0] mem_reads_d;
  logic [CTR_W-1:0] mem_latency_d;
  logic [CTR_W-1:0] stall_cycles_d;
  logic             err_q;

  // Adds an increment to a counter, either wrapping or sticking at all-ones.
  function automatic logic [CTR_W-1:0] acc(input logic [CTR_W-1:0] cur,
                                           input logic [CTR_W-1:0] inc);
    logic [CTR_W:0] s;
    s = {1'b0, cur} + {1'b0, inc};
    if ((SATURATE != 0) && s[CTR_W])
      return {CTR_W{1'b1}};
    return s[CTR_W-1:0];
  endfunction

  assign req_fire = perf.mem_req_valid & perf.mem_req_ready;
  assign rsp_fire = perf.mem_rsp_valid & perf.mem_rsp_ready;

  // Population count of request and response handshakes this cycle.
  always_comb begin
    nreq = '0;
    nrsp = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      nreq = nreq + CNT_W'(req_fire[i]);
      nrsp = nrsp + CNT_W'(rsp_fire[i]);
    end
  end

  // Next in-flight count, clamped to [0, MAX_PENDING] with an error on clamp.
  always_comb begin
    pend_sum  = $signed({{(CALC_W-PEND_W){1'b0}}, pending_q})
              + $signed({{(CALC_W-CNT_W){1'b0}}, nreq})
              - $signed({{(CALC_W-CNT_W){1'b0}}, nrsp});
    pending_d = pending_q;
    pend_err  = 1'b0;
    if (pend_sum < 0) begin
      pending_d = '0;
      pend_err  = 1'b1;
    end else if (pend_sum > $signed(CALC_W'(MAX_PENDING))) begin
      pending_d = PEND_W'(MAX_PENDING);
      pend_err  = 1'b1;
    end else begin
      pending_d = pend_sum[PEND_W-1:0];
    end
  end

  // Candidate counter values; latency uses the occupancy before this cycle's events.
  always_comb begin
    mem_reads_d    = acc(mem_reads_q,    CTR_W'(nreq));
    mem_latency_d  = acc(mem_latency_q,  CTR_W'(pending_q));
    stall_cycles_d = acc(stall_cycles_q, CTR_W'(perf.stall));
  end

  // Register state: reset dominates, clear beats accumulation, pending always tracks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q      <= '0;
      err_q          <= 1'b0;
      mem_reads_q    <= '0;
      mem_latency_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (pend_err)
        err_q <= 1'b1;
      if (clear) begin
        mem_reads_q    <= '0;
        mem_latency_q  <= '0;
        stall_cycles_q <= '0;
      end else if (perf_en) begin
        mem_reads_q    <= mem_reads_d;
        mem_latency_q  <= mem_latency_d;
        stall_cycles_q <= stall_cycles_d;
      end
    end
  end

  assign perf.mem_reads    = mem_reads_q;
  assign perf.mem_latency  = mem_latency_q;
  assign perf.stall_cycles = stall_cycles_q;
  assign perf.pending      = pending_q;
  assign perf.err          = err_q;

endmodule

// File: tb/tb_tex_perf_counters.sv
// Directed self-checking bench for tex_perf_counters: a full-width wrapping
// instance plus two 8-bit instances (saturating and wrapping) for overflow.
module tb_tex_perf_counters;

  logic clk;
  logic reset;
  logic perf_en;
  logic clear;
  logic perf_en8;
  logic clear8;

  int vectors;
  int miscompares;

  tex_perf_counters_if #(.NUM_REQS(4), .CTR_W(44), .PEND_W(7)) m_if ();
  tex_perf_counters_if #(.NUM_REQS(4), .CTR_W(8),  .PEND_W(7)) s_if ();
  tex_perf_counters_if #(.NUM_REQS(4), .CTR_W(8),  .PEND_W(7)) w_if ();

  tex_perf_counters #(.NUM_REQS(4), .CTR_W(44), .MAX_PENDING(64), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .perf_en(perf_en), .clear(clear), .perf(m_if));

  tex_perf_counters #(.NUM_REQS(4), .CTR_W(8), .MAX_PENDING(64), .SATURATE(1)) dut_sat8 (
    .clk(clk), .reset(reset), .perf_en(perf_en8), .clear(clear8), .perf(s_if));

  tex_perf_counters #(.NUM_REQS(4), .CTR_W(8), .MAX_PENDING(64), .SATURATE(0)) dut_wrap8 (
    .clk(clk), .reset(reset), .perf_en(perf_en8), .clear(clear8), .perf(w_if));

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] req_v, input logic [3:0] req_r,
                               input logic [3:0] rsp_v, input logic [3:0] rsp_r,
                               input logic stall_in, input logic en, input logic clr);
    m_if.mem_req_valid = req_v;
    m_if.mem_req_ready = req_r;
    m_if.mem_rsp_valid = rsp_v;
    m_if.mem_rsp_ready = rsp_r;
    m_if.stall         = stall_in;
    perf_en            = en;
    clear              = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear8      = 1'b0;
    perf_en8    = 1'b1;
    s_if.mem_req_valid = '0; s_if.mem_req_ready = '0;
    s_if.mem_rsp_valid = '0; s_if.mem_rsp_ready = '0; s_if.stall = 1'b0;
    w_if.mem_req_valid = '0; w_if.mem_req_ready = '0;
    w_if.mem_rsp_valid = '0; w_if.mem_rsp_ready = '0; w_if.stall = 1'b0;

    $display("[TB] reset with all handshakes active");
    reset = 1'b0;
    applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("rst_reads",   64'(m_if.mem_reads),    64'd0);
    checkOutput("rst_latency", 64'(m_if.mem_latency),  64'd0);
    checkOutput("rst_stall",   64'(m_if.stall_cycles), 64'd0);
    checkOutput("rst_pending", 64'(m_if.pending),      64'd0);
    checkOutput("rst_err",     64'(m_if.err),          64'd0);

    $display("[TB] two requests, latency accumulation");
    reset = 1'b1;
    applyStimulus(4'b0101, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("req_reads",   64'(m_if.mem_reads),   64'd2);
    checkOutput("req_pending", 64'(m_if.pending),     64'd2);
    checkOutput("req_latency", 64'(m_if.mem_latency), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("lat_after5",  64'(m_if.mem_latency),  64'd10);
    checkOutput("lat_reads",   64'(m_if.mem_reads),    64'd2);
    checkOutput("lat_stall",   64'(m_if.stall_cycles), 64'd0);

    $display("[TB] response underflow and sticky error");
    applyStimulus(4'h0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("uf_pending", 64'(m_if.pending),     64'd0);
    checkOutput("uf_err",     64'(m_if.err),         64'd1);
    checkOutput("uf_latency", 64'(m_if.mem_latency), 64'd12);
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_reads",   64'(m_if.mem_reads),    64'd0);
    checkOutput("clr_latency", 64'(m_if.mem_latency),  64'd0);
    checkOutput("clr_stall",   64'(m_if.stall_cycles), 64'd0);
    checkOutput("clr_err",     64'(m_if.err),          64'd1);

    $display("[TB] counting disabled, then re-enabled");
    applyStimulus(4'b0111, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("dis_reads",   64'(m_if.mem_reads),    64'd0);
    checkOutput("dis_latency", 64'(m_if.mem_latency),  64'd0);
    checkOutput("dis_stall",   64'(m_if.stall_cycles), 64'd0);
    checkOutput("dis_pending", 64'(m_if.pending),      64'd3);
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("en_stall",   64'(m_if.stall_cycles), 64'd3);
    checkOutput("en_latency", 64'(m_if.mem_latency),  64'd9);
    checkOutput("en_reads",   64'(m_if.mem_reads),    64'd0);

    $display("[TB] clear beats same-cycle events");
    applyStimulus(4'b0010, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("cw_reads",   64'(m_if.mem_reads),    64'd0);
    checkOutput("cw_latency", 64'(m_if.mem_latency),  64'd0);
    checkOutput("cw_stall",   64'(m_if.stall_cycles), 64'd0);
    checkOutput("cw_pending", 64'(m_if.pending),      64'd4);
    tick();
    checkOutput("cw_lat_next", 64'(m_if.mem_latency), 64'd4);

    $display("[TB] request and response on the same channel");
    applyStimulus(4'b0001, 4'hF, 4'b0001, 4'hF, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("same_pending", 64'(m_if.pending),      64'd4);
    checkOutput("same_reads",   64'(m_if.mem_reads),    64'd1);
    checkOutput("same_latency", 64'(m_if.mem_latency),  64'd8);
    checkOutput("same_stall",   64'(m_if.stall_cycles), 64'd0);

    $display("[TB] in-flight overflow clamps");
    applyStimulus(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("of_pending", 64'(m_if.pending),     64'd64);
    checkOutput("of_err",     64'(m_if.err),         64'd1);
    checkOutput("of_latency", 64'(m_if.mem_latency), 64'd8);

    $display("[TB] 8-bit counter overflow, saturate vs wrap");
    s_if.stall = 1'b1;
    w_if.stall = 1'b1;
    for (int i = 0; i < 250; i++) tick();
    checkOutput("pre_sat",  64'(s_if.stall_cycles), 64'd250);
    checkOutput("pre_wrap", 64'(w_if.stall_cycles), 64'd250);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("sat_255", 64'(s_if.stall_cycles), 64'd255);
    checkOutput("wrap_4",  64'(w_if.stall_cycles), 64'd4);
    tick();
    checkOutput("sat_hold", 64'(s_if.stall_cycles), 64'd255);
    checkOutput("wrap_5",   64'(w_if.stall_cycles), 64'd5);
    s_if.stall = 1'b0;
    w_if.stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
